// File: rtl/ap_status_recorder.sv
// Transaction recorder for an HLS ap_ctrl_hs/ap_ctrl_chain block: timestamps start/done into a record FIFO.
// Optional per-transaction stall counting is compiled in when AP_STATUS_STALL_EN is defined.
module ap_status_recorder #(
  parameter int CNT_W = 32,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [15:0]      rec_index,
  output logic [CNT_W-1:0] rec_start,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_interval,
  output logic [CNT_W-1:0] rec_stall,
  output logic             rec_partial,
  output logic [15:0]      drop_cnt,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_CLOSED} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end else begin
      return v;
    end
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] t0_q, t0_d, prev_q, prev_d, intv_q, intv_d;
  logic             has_prev_q, has_prev_d;
  logic [15:0]      idx_q, drop_q;
  logic             busy_q;
  logic             push_s, part_s, done_ok_s;
  logic [CNT_W-1:0] r_start_s, r_lat_s, r_intv_s, new_intv_s;
`ifdef AP_STATUS_STALL_EN
  logic [CNT_W-1:0] stall_q, stall_d, r_stall_s;
  logic [CNT_W-1:0] stall_mem [DEPTH];
`endif

  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      count_q, count_d;
  logic             valid_q, full_s, pop_s, push_ok_s, drop_s;
  logic [15:0]      idx_mem   [DEPTH];
  logic [CNT_W-1:0] start_mem [DEPTH];
  logic [CNT_W-1:0] lat_mem   [DEPTH];
  logic [CNT_W-1:0] intv_mem  [DEPTH];
  logic             part_mem  [DEPTH];

  logic unused_ready;
  assign unused_ready = ap_ready;

  // Transaction FSM: start detection, completion/partial record generation.
  always_comb begin
    state_d    = state_q;
    t0_d       = t0_q;
    prev_d     = prev_q;
    has_prev_d = has_prev_q;
    intv_d     = intv_q;
    push_s     = 1'b0;
    part_s     = 1'b0;
    done_ok_s  = ap_done && ap_continue;
    r_start_s  = t0_q;
    r_lat_s    = cyc_q - t0_q + CNT_W'(1);
    r_intv_s   = intv_q;
    new_intv_s = has_prev_q ? (cyc_q - prev_q) : {CNT_W{1'b0}};
`ifdef AP_STATUS_STALL_EN
    stall_d    = stall_q;
    r_stall_s  = stall_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (finish) begin
          state_d = S_CLOSED;
        end else if (ap_start) begin
          t0_d       = cyc_q;
          prev_d     = cyc_q;
          has_prev_d = 1'b1;
          intv_d     = new_intv_s;
`ifdef AP_STATUS_STALL_EN
          stall_d    = {CNT_W{1'b0}};
          r_stall_s  = {CNT_W{1'b0}};
`endif
          // A zero-latency module completes in its own start cycle.
          if (done_ok_s) begin
            push_s    = 1'b1;
            r_start_s = cyc_q;
            r_lat_s   = CNT_W'(1);
            r_intv_s  = new_intv_s;
          end else if (ap_done) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN, S_HOLD: begin
`ifdef AP_STATUS_STALL_EN
        stall_d   = sat_inc(stall_q, ap_done && !ap_continue);
        r_stall_s = stall_d;
`endif
        if (finish) begin
          state_d = S_CLOSED;
          push_s  = 1'b1;
          part_s  = !done_ok_s;
        end else if (done_ok_s) begin
          state_d = S_IDLE;
          push_s  = 1'b1;
        end else if (ap_done) begin
          state_d = S_HOLD;
        end else begin
          state_d = state_q;
        end
      end
      S_CLOSED: state_d = S_CLOSED;
      default:  state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping: a full FIFO still accepts a push when the head pops in the same cycle.
  always_comb begin
    full_s    = (count_q == (AW+1)'(DEPTH));
    pop_s     = (count_q != {(AW+1){1'b0}}) && rec_ready;
    push_ok_s = push_s && (!full_s || pop_s);
    drop_s    = push_s && !push_ok_s;
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: cycle counter, FSM, timing registers and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cyc_q      <= {CNT_W{1'b0}};
      t0_q       <= {CNT_W{1'b0}};
      prev_q     <= {CNT_W{1'b0}};
      intv_q     <= {CNT_W{1'b0}};
      has_prev_q <= 1'b0;
      idx_q      <= 16'h0000;
      drop_q     <= 16'h0000;
      busy_q     <= 1'b0;
`ifdef AP_STATUS_STALL_EN
      stall_q    <= {CNT_W{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_q + CNT_W'(1);
      t0_q       <= t0_d;
      prev_q     <= prev_d;
      intv_q     <= intv_d;
      has_prev_q <= has_prev_d;
      busy_q     <= (state_d == S_RUN) || (state_d == S_HOLD);
`ifdef AP_STATUS_STALL_EN
      stall_q    <= stall_d;
`endif
      if (push_s) idx_q <= idx_q + 16'd1;
      if (drop_s && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  // Record FIFO storage and pointers; contents are cleared on reset so the head reads zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q    <= {AW{1'b0}};
      rd_q    <= {AW{1'b0}};
      count_q <= {(AW+1){1'b0}};
      valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        idx_mem[i]   <= 16'h0000;
        start_mem[i] <= {CNT_W{1'b0}};
        lat_mem[i]   <= {CNT_W{1'b0}};
        intv_mem[i]  <= {CNT_W{1'b0}};
        part_mem[i]  <= 1'b0;
`ifdef AP_STATUS_STALL_EN
        stall_mem[i] <= {CNT_W{1'b0}};
`endif
      end
    end else begin
      if (push_ok_s) begin
        idx_mem[wr_q]   <= idx_q;
        start_mem[wr_q] <= r_start_s;
        lat_mem[wr_q]   <= r_lat_s;
        intv_mem[wr_q]  <= r_intv_s;
        part_mem[wr_q]  <= part_s;
`ifdef AP_STATUS_STALL_EN
        stall_mem[wr_q] <= r_stall_s;
`endif
        wr_q <= wr_q + AW'(1);
      end
      if (pop_s) rd_q <= rd_q + AW'(1);
      count_q <= count_d;
      valid_q <= (count_d != {(AW+1){1'b0}});
    end
  end

  assign rec_valid    = valid_q;
  assign rec_index    = idx_mem[rd_q];
  assign rec_start    = start_mem[rd_q];
  assign rec_latency  = lat_mem[rd_q];
  assign rec_interval = intv_mem[rd_q];
  assign rec_partial  = part_mem[rd_q];
`ifdef AP_STATUS_STALL_EN
  assign rec_stall    = stall_mem[rd_q];
`else
  assign rec_stall    = {CNT_W{1'b0}};
`endif
  assign drop_cnt     = drop_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_ap_status_recorder.sv
// Bench for ap_status_recorder: directed and random transactions against a record-level reference queue.
module tb_ap_status_recorder;

  typedef struct packed {
    logic [15:0] idx;
    logic [31:0] start;
    logic [31:0] lat;
    logic [31:0] intv;
    logic [31:0] stall;
    logic        partial;
  } rec_t;

  logic clock = 1'b0, reset = 1'b1;
  logic ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b1;
  logic finish = 1'b0, rec_ready = 1'b0;

  logic        rec_valid, rec_partial, busy;
  logic [15:0] rec_index, drop_cnt;
  logic [31:0] rec_start, rec_latency, rec_interval, rec_stall;

  logic        v8, part8, busy8;
  logic [15:0] idx8, drop8;
  logic [7:0]  start8, lat8, intv8, stall8;

  ap_status_recorder #(.CNT_W(32), .DEPTH(16)) u_dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_index(rec_index),
    .rec_start(rec_start), .rec_latency(rec_latency), .rec_interval(rec_interval),
    .rec_stall(rec_stall), .rec_partial(rec_partial), .drop_cnt(drop_cnt), .busy(busy)
  );

  ap_status_recorder #(.CNT_W(8), .DEPTH(16)) u_dut8 (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .rec_valid(v8), .rec_ready(rec_ready), .rec_index(idx8),
    .rec_start(start8), .rec_latency(lat8), .rec_interval(intv8),
    .rec_stall(stall8), .rec_partial(part8), .drop_cnt(drop8), .busy(busy8)
  );

  always #5 clock = ~clock;

  rec_t        mq[$];
  int          m_idx, m_drop, now_cyc, n_cmp, n_bad;
  logic [31:0] m_prev;
  bit          m_has_prev, m_closed;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    now_cyc++;
    ap_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    reset = 1'b1; ap_start = 1'b0; ap_done = 1'b0; ap_continue = 1'b1;
    finish = 1'b0; rec_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    now_cyc = 0;
    mq.delete(); m_idx = 0; m_drop = 0; m_has_prev = 1'b0; m_prev = 32'd0; m_closed = 1'b0;
  endtask

  task automatic wait_to(input int t);
    while (now_cyc < t) step();
  endtask

  // Reference record: every field is derived from the start and completion cycles.
  task automatic model_rec(input int s, input int c, input int stall, input bit part);
    rec_t r;
    if (m_closed) return;
    r.idx = m_idx[15:0];
    m_idx++;
    r.start = 32'(s);
    r.lat = 32'(c - s + 1);
    r.intv = m_has_prev ? (32'(s) - m_prev) : 32'd0;
    m_prev = 32'(s);
    m_has_prev = 1'b1;
`ifdef AP_STATUS_STALL_EN
    r.stall = 32'(stall);
`else
    r.stall = 32'd0;
`endif
    r.partial = part;
    if (mq.size() < 16) mq.push_back(r);
    else if (m_drop < 65535) m_drop++;
  endtask

  task automatic check_fields(input rec_t e);
    logic [31:0] tmp;
    chk("valid", rec_valid, 1);
    chk("index", rec_index, e.idx);
    chk("start", rec_start, e.start);
    chk("latency", rec_latency, e.lat);
    chk("interval", rec_interval, e.intv);
    chk("stall", rec_stall, e.stall);
    chk("partial", rec_partial, e.partial);
    chk("drop", drop_cnt, m_drop);
    chk("valid8", v8, 1);
    chk("index8", idx8, e.idx);
    tmp = e.start; chk("start8", start8, tmp[7:0]);
    tmp = e.lat;   chk("latency8", lat8, tmp[7:0]);
    tmp = e.intv;  chk("interval8", intv8, tmp[7:0]);
    chk("partial8", part8, e.partial);
  endtask

  task automatic pop_head();
    rec_t e;
    e = mq.pop_front();
    check_fields(e);
    rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
  endtask

  task automatic drain();
    while (mq.size() > 0) pop_head();
    chk("empty", rec_valid, 0);
    chk("empty8", v8, 0);
    chk("drop_after_drain", drop_cnt, m_drop);
  endtask

  // One transaction: start after gap idle cycles, complete lat cycles later (inclusive),
  // with the final stall cycles showing done without continue.
  task automatic txn(input int gap, input int lat, input int stall, input bit hold, input bit pop_at_done);
    int s, c;
    rec_t e;
    repeat (gap) step();
    s = now_cyc;
    c = s + lat - 1;
    ap_start = 1'b1;
    if (lat > 1) begin
      step();
      ap_start = hold;
      while (now_cyc < c) begin
        ap_done = (now_cyc >= c - stall);
        ap_continue = !(now_cyc >= c - stall);
        step();
      end
      chk("busy_run", busy, 1);
    end
    ap_done = 1'b1;
    ap_continue = 1'b1;
    if (pop_at_done && mq.size() > 0) begin
      e = mq.pop_front();
      check_fields(e);
      rec_ready = 1'b1;
    end
    step();
    rec_ready = 1'b0;
    ap_done = 1'b0;
    ap_start = 1'b0;
    model_rec(s, c, stall, 1'b0);
  endtask

  initial begin
    rec_t e;
    int lat, stall;
    n_cmp = 0; n_bad = 0;

    // Reset state
    do_reset();
    chk("rst_valid", rec_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_index", rec_index, 0);
    chk("rst_start", rec_start, 0);
    chk("rst_latency", rec_latency, 0);
    chk("rst_interval", rec_interval, 0);
    chk("rst_stall", rec_stall, 0);
    chk("rst_partial", rec_partial, 0);
    chk("rst_valid8", v8, 0);

    // Single transaction: start at 5, done at 14
    wait_to(5);
    txn(0, 10, 0, 1'b0, 1'b0);
    chk("t1_visible_cycle", now_cyc, 15);
    chk("t1_busy_after", busy, 0);
    chk("t1_latency", rec_latency, 10);
    drain();

    // Back-to-back with ap_start held through the completion cycle
    do_reset();
    wait_to(5);
    txn(0, 10, 0, 1'b1, 1'b0);
    txn(0, 10, 0, 1'b0, 1'b0);
    drain();

    // Done held without continue for 3 cycles
    do_reset();
    wait_to(5);
    txn(0, 13, 3, 1'b0, 1'b0);
    chk("t3_latency", rec_latency, 13);
    drain();

    // Overflow: 18 transactions into a 16-deep FIFO with no reader
    do_reset();
    for (int i = 0; i < 18; i++) txn(1, 3, 0, 1'b0, 1'b0);
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_drop8", drop8, 2);
    drain();

    // Full FIFO with a pop in the completion cycle accepts the push
    for (int i = 0; i < 16; i++) txn(1, 2, 0, 1'b0, 1'b0);
    txn(1, 4, 1, 1'b0, 1'b1);
    chk("fullpop_drop", drop_cnt, 2);
    drain();

    // finish closes an in-flight transaction as a partial record
    do_reset();
    wait_to(100);
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    wait_to(107);
    finish = 1'b1;
    chk("fin_busy_before", busy, 1);
    step();
    finish = 1'b0;
    model_rec(100, 107, 0, 1'b1);
    m_closed = 1'b1;
    chk("fin_busy_after", busy, 0);
    for (int i = 0; i < 3; i++) begin
      ap_start = 1'b1; step(); ap_start = 1'b0;
      ap_done = 1'b1; step(); ap_done = 1'b0;
      step();
      chk("closed_busy", busy, 0);
    end
    chk("fin_partial", rec_partial, 1);
    chk("fin_latency", rec_latency, 8);
    drain();

    // 8-bit counter wrap: start at 250, done at 260 (4 after wrap)
    do_reset();
    wait_to(250);
    txn(0, 11, 0, 1'b0, 1'b0);
    chk("wrap_latency8", lat8, 11);
    chk("wrap_start8", start8, 250);
    drain();

    // Random transactions with occasional same-cycle pops and drains
    do_reset();
    for (int i = 0; i < 40; i++) begin
      lat = $urandom_range(1, 12);
      stall = (lat >= 3) ? $urandom_range(0, lat - 2) : 0;
      txn($urandom_range(0, 3), lat, stall, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      if (mq.size() >= 14 || $urandom_range(0, 4) == 0) drain();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ap_status_recorder.md
# ap_status_recorder

Synthesizable transaction recorder that sits beside one HLS `ap_ctrl_hs`/`ap_ctrl_chain` module (for example `myproject` or a `pairwise_dist_sq_rbf` instance) and turns its start/ready/done handshake into timestamped transaction records. Each record gives start time, latency, start-to-start interval and optional stall count, and is buffered in a small FIFO for a downstream reader (CSV dumper, AXI-Lite shim). It provides the on-chip counterpart of the simulation module-status monitors, so hardware runs produce the same per-transaction statistics.

## Interface
- `CNT_W`, 32: width of the cycle counter and of every time field.
- `DEPTH`, 16: record FIFO depth; power of two, ≥2.
- `clock`  in  1: sole clock; all logic is rising-edge.
- `reset`  in  1: synchronous, active-high; clears all state.
- `ap_start`, `ap_ready`, `ap_done`, `ap_continue`  in  1 each: handshake of the monitored module. Tie `ap_continue` to 1 for `ap_ctrl_hs`.
- `finish`  in  1: end of run; closes recording (sticky).
- `rec_valid`  out  1: FIFO head valid.
- `rec_ready`  in  1: reader pops the head when `rec_valid & rec_ready`.
- `rec_index`  out  16: transaction sequence number, from 0, wraps.
- `rec_start`  out  CNT_W: cycle-counter value at start.
- `rec_latency`  out  CNT_W: cycles from start to completion, inclusive.
- `rec_interval`  out  CNT_W: start minus previous start; 0 for index 0.
- `rec_stall`  out  CNT_W: done-without-continue cycles (see Configuration).
- `rec_partial`  out  1: record was closed by `finish`, not by done.
- `drop_cnt`  out  16: records lost to a full FIFO; saturates at 0xFFFF.
- `busy`  out  1: a transaction is in flight.

## Operation
- Free-running `cyc` counter: 0 in the first cycle after reset deasserts, then +1 per cycle, wrapping mod 2^CNT_W. All differences are computed mod 2^CNT_W.
- FSM states:
  - IDLE: if `ap_start & !closed`, latch `t0=cyc`, compute interval, go RUN.
  - RUN: `ap_ready` is informational only. On `ap_done & ap_continue`, complete and go IDLE. On `ap_done & !ap_continue`, go HOLD.
  - HOLD: on `ap_done & ap_continue`, complete and go IDLE.
  - CLOSED: entered after `finish`; terminal until reset.
- Completion in cycle c pushes a record with `latency = c - t0 + 1`. The start cycle is not re-detected in that same cycle. If `ap_start` is still high in cycle c+1, a new transaction starts at c+1.
- Start and done in the same IDLE cycle (zero-latency module): start is latched and the record is completed that cycle with latency 1.
- `finish` high in any cycle:
  - `closed` is set.
  - If the FSM is in RUN or HOLD, a record is pushed that cycle with `rec_partial=1` and `latency = cyc - t0 + 1`. The FSM goes CLOSED.
  - After that, no further records are created. Popping continues to work.
- `rec_index` increments once per pushed record, including partial records.
- FIFO:
  - Push when full and no pop in the same cycle: the record is discarded and `drop_cnt` increments.
  - Push while full with a pop in the same cycle: the push is accepted.
  - Pop while empty: ignored.
- Reset mid-transaction discards the in-flight transaction and clears the FIFO contents. No record is emitted.

## Timing
- Reset values:
  - `rec_valid=0`, `busy=0`, `drop_cnt=0`.
  - All record outputs 0; `rec_partial=0`.
  - FSM is in IDLE; `closed=0`.
- `busy` is registered: high from the cycle after the start cycle through the completion cycle, then low the next cycle.
- Record pushed in cycle c appears at the head with `rec_valid=1` in cycle c+1 if the FIFO was empty. Push-to-visible latency is 1.
- Record outputs are registered FIFO-head data. They are stable while `rec_valid & !rec_ready`.
- Sustained throughput: one record per cycle in and one per cycle out.

## Configuration
- `AP_STATUS_STALL_EN` defined:
  - A per-transaction stall counter counts RUN/HOLD cycles with `ap_done & !ap_continue`, saturating at all-ones.
  - The count is stored in the FIFO and driven on `rec_stall`.
- Not defined:
  - No stall counter and no stall storage.
  - `rec_stall` is tied to 0.
  - HOLD still exists, so latency still includes the hold cycles.

## Test plan
- Reset release, `ap_start` high at cyc=5, `ap_done&ap_continue` at cyc=14 -> next cycle: `rec_valid=1`, index 0, start 5, latency 10, interval 0, partial 0.
- Back-to-back: done at cyc=14 with `ap_start` held high; second done at cyc=24 -> second record: start 15, latency 10, interval 10, index 1.
- `ap_continue=0` for 3 cycles while `ap_done=1` (cyc 14–16), continue at 17:
  - Latency 13.
  - `rec_stall=3` with `AP_STATUS_STALL_EN`; 0 without it.
- DEPTH=16, `rec_ready=0`, 18 transactions -> 16 records held, `drop_cnt=2`. Then `rec_ready=1` -> indices 0..15 popped in order, no extras.
- Start at cyc=100, `finish` at cyc=107 -> one record with partial=1, latency 8. Later `ap_start` pulses produce no records; `busy=0`.
- `CNT_W=8`, start at cyc=250, done at cyc=4 (after wrap) -> latency 11.
